// File: rtl/simd_acc_p_stage_if.sv
// simd_acc_p_stage_if: ALU-side and result-side signals of the SIMD accumulator stage.
interface simd_acc_p_stage_if #(parameter int LEN_W = 8);
    logic [1:0]       USE_SIMD;
    logic [LEN_W-1:0] acc_len;
    logic             in_valid;
    logic             flush;
    logic [31:0]      S;
    logic [3:0]       result_SIMD_carry_out;
    logic [31:0]      W;
    logic [1:0]       USE_SIMD_alu;
    logic [31:0]      P;
    logic [3:0]       P_carry;
    logic             P_valid;
    logic             busy;

    modport master (
        output USE_SIMD, acc_len, in_valid, flush, S, result_SIMD_carry_out,
        input  W, USE_SIMD_alu, P, P_carry, P_valid, busy
    );

    modport slave (
        input  USE_SIMD, acc_len, in_valid, flush, S, result_SIMD_carry_out,
        output W, USE_SIMD_alu, P, P_carry, P_valid, busy
    );
endinterface

// File: rtl/simd_acc_p_stage.sv
// simd_acc_p_stage: per-lane accumulator feeding W back into the SIMD ALU and
// registering the framed result P with sticky lane carries.
module simd_acc_p_stage #(
    parameter int LEN_W = 8
) (
    input logic               clk,
    input logic               rst_n,
    simd_acc_p_stage_if.slave bus
);
    typedef enum logic {IDLE, ACC} state_t;

    state_t           state, state_n;
    logic [31:0]      acc_q, p_q;
    logic [LEN_W-1:0] len_q, cnt, len_in;
    logic [1:0]       mode_q, mode;
    logic [3:0]       sticky, mask, mcarry, pc_q;
    logic             pv_q, beat, done;

    // first beat of a frame uses the live mode, later beats the latched one
    always_comb begin
        mode    = state == ACC ? mode_q : bus.USE_SIMD;
        mask    = mode == 2'b00 ? 4'b1000 : mode == 2'b01 ? 4'b1010 : 4'b1111;
        mcarry  = bus.result_SIMD_carry_out & mask;
        len_in  = bus.acc_len == '0 ? LEN_W'(1) : bus.acc_len;
        beat    = bus.in_valid & ~bus.flush;
        done    = beat & (state == IDLE ? len_in == LEN_W'(1) : cnt + LEN_W'(1) == len_q);
        state_n = bus.flush ? IDLE : beat ? (done ? IDLE : ACC) : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc_q  <= '0;
            cnt    <= '0;
            len_q  <= '0;
            mode_q <= 2'b00;
            sticky <= '0;
            p_q    <= '0;
            pc_q   <= '0;
            pv_q   <= 1'b0;
        end else begin
            state <= state_n;
            pv_q  <= done;
            if (bus.flush) begin
                acc_q  <= '0;
                cnt    <= '0;
                sticky <= '0;
            end else if (beat) begin
                acc_q  <= bus.S;
                cnt    <= state == IDLE ? LEN_W'(1) : cnt + LEN_W'(1);
                sticky <= (state == IDLE ? 4'b0000 : sticky) | mcarry;
                if (state == IDLE) begin
                    mode_q <= bus.USE_SIMD;
                    len_q  <= len_in;
                end
                if (done) begin
                    p_q  <= bus.S;
                    pc_q <= (state == IDLE ? 4'b0000 : sticky) | mcarry;
                end
            end
        end
    end

    assign bus.W            = state == ACC ? acc_q : 32'h0;
    assign bus.USE_SIMD_alu = mode;
    assign bus.P            = p_q;
    assign bus.P_carry      = pc_q;
    assign bus.P_valid      = pv_q;
    assign bus.busy         = state == ACC;
endmodule

// File: tb/tb_simd_acc_p_stage.sv
// tb_simd_acc_p_stage: SIMD ALU model closing the W->S loop, scoreboard of framed results.
module tb_simd_acc_p_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    simd_acc_p_stage_if #(.LEN_W(8)) bus();
    simd_acc_p_stage #(.LEN_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [31:0] opnd;
    logic [35:0] exp_q[$];
    logic [35:0] e;
    int n_chk = 0;
    int n_fail = 0;

    // ALU: four 8-bit slices, carry chained inside a lane, every slice carry reported
    function automatic logic [35:0] alu(input logic [31:0] w, input logic [31:0] o, input logic [1:0] m);
        logic [3:0] cy;
        logic [31:0] s;
        logic c;
        c = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if ((m == 2'b01 && i == 2) || (m[1] && i != 0)) c = 1'b0;
            {c, s[8*i +: 8]} = w[8*i +: 8] + o[8*i +: 8] + {7'b0, c};
            cy[i] = c;
        end
        return {cy, s};
    endfunction

    assign {bus.result_SIMD_carry_out, bus.S} = alu(bus.W, opnd, bus.USE_SIMD_alu);

    // reference lane add: result plus only the carries a lane really produces
    function automatic logic [35:0] ref_add(input logic [31:0] a, input logic [31:0] o, input logic [1:0] m);
        logic [32:0] t;
        logic [16:0] h0, h1;
        logic [8:0] b;
        logic [35:0] r;
        if (m == 2'b00) begin
            t = a + o;
            r = {t[32], 3'b000, t[31:0]};
        end else if (m == 2'b01) begin
            h0 = a[15:0] + o[15:0];
            h1 = a[31:16] + o[31:16];
            r = {h1[16], 1'b0, h0[16], 1'b0, h1[15:0], h0[15:0]};
        end else begin
            r = '0;
            for (int i = 0; i < 4; i++) begin
                b = a[8*i +: 8] + o[8*i +: 8];
                r[8*i +: 8] = b[7:0];
                r[32+i] = b[8];
            end
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.P_valid) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_p_valid P=%h P_carry=%b (no frame expected)", bus.P, bus.P_carry);
            end else begin
                e = exp_q.pop_front();
                if ({bus.P_carry, bus.P} !== e) begin
                    n_fail++;
                    $display("FAIL p_result P=%h P_carry=%b expected P=%h P_carry=%b", bus.P, bus.P_carry, e[31:0], e[35:32]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // chg >= 0: USE_SIMD switches to 00 from that beat on; frame keeps mode m
    task automatic frame(input logic [1:0] m, input logic [7:0] len, input logic [31:0] o[4], input int chg);
        int n;
        logic [31:0] acc;
        logic [3:0] st;
        logic [35:0] r;
        n = len == 0 ? 1 : int'(len);
        acc = '0;
        st = '0;
        for (int i = 0; i < n; i++) begin
            r = ref_add(acc, o[i], m);
            acc = r[31:0];
            st |= r[35:32];
        end
        exp_q.push_back({st, acc});
        for (int i = 0; i < n; i++) begin
            bus.USE_SIMD = (chg >= 0 && i >= chg) ? 2'b00 : m;
            bus.acc_len  = len;
            bus.in_valid = 1'b1;
            bus.flush    = 1'b0;
            opnd = o[i];
            n_chk++;
            if (i == 0 && bus.W !== 32'h0) begin
                n_fail++;
                $display("FAIL w_frame_start W=%h expected 00000000", bus.W);
            end
            if (i > 0) begin
                n_chk += 2;
                if (bus.USE_SIMD_alu !== m) begin
                    n_fail++;
                    $display("FAIL mode_hold USE_SIMD_alu=%b expected %b", bus.USE_SIMD_alu, m);
                end
                if (bus.busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL busy_in_frame busy=%b expected 1", bus.busy);
                end
            end
            step();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.USE_SIMD = 2'b10;
        bus.acc_len = 8'd1;
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        opnd = '0;
        step();
        step();
        n_chk += 5;
        if (bus.P !== 32'h0) begin n_fail++; $display("FAIL reset_p P=%h expected 0", bus.P); end
        if (bus.P_carry !== 4'h0) begin n_fail++; $display("FAIL reset_pc P_carry=%b expected 0000", bus.P_carry); end
        if (bus.P_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pv P_valid=%b expected 0", bus.P_valid); end
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy busy=%b expected 0", bus.busy); end
        if (bus.USE_SIMD_alu !== 2'b10) begin n_fail++; $display("FAIL reset_mode USE_SIMD_alu=%b expected 10", bus.USE_SIMD_alu); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_mode16();
        logic [31:0] o[4];
        o = '{32'h10, 32'h20, 32'h30, 32'h0};
        frame(2'b00, 8'd3, o, -1);
        n_chk += 2;
        if (bus.P !== 32'h60) begin n_fail++; $display("FAIL m16_p P=%h expected 00000060", bus.P); end
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL m16_busy_fall busy=%b expected 0", bus.busy); end
        step();
        n_chk++;
        if (bus.P_valid !== 1'b0) begin n_fail++; $display("FAIL m16_pulse P_valid=%b expected 0", bus.P_valid); end
    endtask

    task automatic test_sum4x4();
        logic [31:0] o[4];
        o = '{32'h90909090, 32'h90909090, 32'h0, 32'h0};
        frame(2'b10, 8'd2, o, -1);
        step();
    endtask

    task automatic test_mode_hold();
        logic [31:0] o[4];
        o = '{32'hC0FFC0FF, 32'hC0FFC0FF, 32'hC0FFC0FF, 32'hC0FFC0FF};
        frame(2'b01, 8'd4, o, 2);
        step();
        o = '{32'h00FF00FF, 32'h00FF00FF, 32'h00FF00FF, 32'h0};
        frame(2'b01, 8'd3, o, -1);
        step();
    endtask

    task automatic test_len_zero();
        logic [31:0] o[4];
        o = '{32'h12345678, 32'h0, 32'h0, 32'h0};
        frame(2'b00, 8'd0, o, -1);
        n_chk += 2;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL len0_busy busy=%b expected 0", bus.busy); end
        if (bus.P_valid !== 1'b1) begin n_fail++; $display("FAIL len0_latency P_valid=%b expected 1", bus.P_valid); end
        step();
    endtask

    task automatic test_flush();
        logic [31:0] prev;
        logic [31:0] o[4];
        prev = bus.P;
        bus.USE_SIMD = 2'b00;
        bus.acc_len = 8'd3;
        bus.in_valid = 1'b1;
        opnd = 32'h100;
        step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        n_chk += 4;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy busy=%b expected 0", bus.busy); end
        if (bus.W !== 32'h0) begin n_fail++; $display("FAIL flush_w W=%h expected 0", bus.W); end
        if (bus.P !== prev) begin n_fail++; $display("FAIL flush_p P=%h expected %h", bus.P, prev); end
        if (bus.P_valid !== 1'b0) begin n_fail++; $display("FAIL flush_pv P_valid=%b expected 0", bus.P_valid); end
        step();
        o = '{32'h5, 32'h6, 32'h0, 32'h0};
        frame(2'b00, 8'd2, o, -1);
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] o[4];
        o = '{32'hFFFFFFFF, 32'h1, 32'h0, 32'h0};
        frame(2'b00, 8'd2, o, -1);
        o = '{32'hAB, 32'h0, 32'h0, 32'h0};
        frame(2'b11, 8'd1, o, -1);
        o = '{32'hF0F0F0F0, 32'h20202020, 32'h0, 32'h0};
        frame(2'b11, 8'd2, o, -1);
        step();
    endtask

    task automatic test_async_reset();
        logic [31:0] o[4];
        bus.USE_SIMD = 2'b10;
        bus.acc_len = 8'd3;
        bus.in_valid = 1'b1;
        opnd = 32'h11111111;
        step();
        bus.USE_SIMD = 2'b01;
        #2 rst_n = 1'b0;
        #1;
        n_chk += 6;
        if (bus.P !== 32'h0) begin n_fail++; $display("FAIL arst_p P=%h expected 0", bus.P); end
        if (bus.P_carry !== 4'h0) begin n_fail++; $display("FAIL arst_pc P_carry=%b expected 0000", bus.P_carry); end
        if (bus.P_valid !== 1'b0) begin n_fail++; $display("FAIL arst_pv P_valid=%b expected 0", bus.P_valid); end
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy busy=%b expected 0", bus.busy); end
        if (bus.W !== 32'h0) begin n_fail++; $display("FAIL arst_w W=%h expected 0", bus.W); end
        if (bus.USE_SIMD_alu !== 2'b01) begin n_fail++; $display("FAIL arst_mode USE_SIMD_alu=%b expected 01", bus.USE_SIMD_alu); end
        bus.in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        o = '{32'h80808080, 32'h80808080, 32'h01010101, 32'h0};
        frame(2'b10, 8'd3, o, -1);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached, %0d results outstanding", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mode16();
        test_sum4x4();
        test_mode_hold();
        test_len_zero();
        test_flush();
        test_back_to_back();
        test_async_reset();
        step();
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL outstanding_results left=%0d expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/simd_acc_p_stage.md
# simd_acc_p_stage

Accumulator and output-register stage directly downstream of the 32-bit SIMD ALU (four 8-bit slices, modes 16x16 / sum_8x8 / sum_4x4). It captures the ALU sum `S` and the per-slice carry outs, and drives the `W` feedback operand back into the ALU so that `acc_len` consecutive beats are summed per lane. It then presents the final result on `P` with a one-cycle valid pulse and per-lane sticky carry flags. It also holds the SIMD mode stable for the ALU for the whole accumulation frame.

## Interface
- `LEN_W`, default 8: width of the beat-count / `acc_len` field.
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `USE_SIMD`: input, 2 bits. Requested mode: 00 = 16x16, 01 = sum_8x8, 10 = sum_4x4, 11 = treated as sum_4x4.
- `acc_len`: input, `LEN_W` bits. Number of beats per frame; 0 is treated as 1.
- `in_valid`: input, 1 bit. The ALU output this cycle is a beat to accumulate.
- `flush`: input, 1 bit. Abort the current frame.
- `S`: input, 32 bits. ALU sum for the current cycle.
- `result_SIMD_carry_out`: input, 4 bits. ALU slice carry outs for the current cycle.
- `W`: output, 32 bits. Feedback operand to the ALU; combinational from state.
- `USE_SIMD_alu`: output, 2 bits. Mode driven to the ALU (the latched frame mode).
- `P`: output, 32 bits. Final accumulated result.
- `P_carry`: output, 4 bits. Sticky per-lane carry flags for `P`.
- `P_valid`: output, 1 bit. One-cycle pulse when `P` and `P_carry` update.
- `busy`: output, 1 bit. High while a frame is in progress (state ACC).

## Operation
- States:
  - IDLE: no partial sum. `W` = 0. `USE_SIMD_alu` = live `USE_SIMD`.
  - ACC: partial sum held in `acc_q`. `W` = `acc_q`. `USE_SIMD_alu` = `mode_q`.
- IDLE with `in_valid` (and no `flush`):
  - Latch `mode_q` ← `USE_SIMD`, `len_q` ← max(`acc_len`, 1), `acc_q` ← `S`, `cnt` ← 1.
  - Sticky carry ← masked `result_SIMD_carry_out`.
  - If `len_q` = 1: complete immediately (see Completion) and stay in IDLE. Otherwise go to ACC.
- ACC with `in_valid`:
  - `acc_q` ← `S`, `cnt` ← `cnt` + 1, sticky ← sticky OR masked carry.
  - When `cnt` + 1 = `len_q`, complete and go to IDLE.
- Completion: `P` ← `S`, `P_carry` ← sticky OR masked carry of the completing beat, `P_valid` = 1 for that clock only.
- Carry lane mask, taken from `mode_q` (or live `USE_SIMD` on a first beat):
  - 16x16: bit 3 only.
  - sum_8x8: bits 1 and 3.
  - sum_4x4 / 11: bits 3:0.
  - Masked-off bits read 0.
- Mode and `acc_len` changes during ACC are ignored until the next frame.
- Sum width: no saturation. `S` wraps modulo the lane width; the wrap is reported only through `P_carry`.
- `in_valid` low: hold all state. `W` keeps presenting `acc_q`.
- `flush`:
  - Go to IDLE and clear `acc_q`, `cnt` and sticky. `P`, `P_carry` are untouched; no `P_valid`.
  - `flush` together with `in_valid`: flush wins and the beat is discarded.
- `cnt` never exceeds `len_q`; there is no wrap of `cnt`.

## Timing
- Reset values: `P` = 0, `P_carry` = 0, `P_valid` = 0, `busy` = 0, `W` = 0, `USE_SIMD_alu` = `USE_SIMD` (IDLE). Internal: `acc_q` = 0, `cnt` = 0, `mode_q` = 00.
- Reset asserted mid-frame: immediate return to IDLE and the partial sum is lost.
- Throughput: one beat per clock; back-to-back frames need no idle cycle.
- Latency: `P_valid` is high in the cycle after the edge that samples the last beat of the frame.
- Combinational loop is closed only through `acc_q`. `W` is registered-state based, and the ALU path `W` → `S` is combinational within one cycle.
- `busy` rises the cycle after the first beat of a frame with `len_q` > 1, and falls in the cycle `P_valid` is high.

## Test plan
- Mode 00, `acc_len` = 3, beats with X+Y = 0x00000010, 0x00000020, 0x00000030 → `P` = 0x00000060, `P_carry` = 0000, `P_valid` a single pulse.
- Mode 10, `acc_len` = 2, each lane X+Y = 0x90 for both beats → `P` = 0x20202020, `P_carry` = 1111.
- Mode 01, `acc_len` = 4, `USE_SIMD` changed to 00 after beat 2 → `USE_SIMD_alu` stays 01 and `P_carry` uses mask 1010.
- `acc_len` = 0 with a single beat of 0x12345678 → `P` = 0x12345678, `P_valid` next cycle, `busy` never high.
- `flush` asserted with `in_valid` on beat 2 of 3 → no `P_valid`, the next frame starts from `W` = 0, and the prior `P` is unchanged.
- `rst_n` pulsed low asynchronously mid-frame → all outputs at reset values before the next clock edge, and the next frame is correct.
